// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection phase scheduler:
// state encodings, approach indices, lamp codes, round-robin pick and lamp decode.
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        ALLRED = 2'd3
    } state_t;

    localparam logic [1:0] IDX_NS = 2'd0;
    localparam logic [1:0] IDX_SN = 2'd1;
    localparam logic [1:0] IDX_EW = 2'd2;
    localparam logic [1:0] IDX_WE = 2'd3;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // First requesting index at or after last+1, wrapping; last itself is tried last.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [11:0] lamp_drive(input state_t st, input logic [1:0] g);
        lamp_drive = {4{LAMP_RED}};
        if (st == GREEN)  lamp_drive[3*int'(g) +: 3] = LAMP_GRN;
        if (st == YELLOW) lamp_drive[3*int'(g) +: 3] = LAMP_YEL;
    endfunction

endpackage

// File: rtl/traffic_phase_sched_bcd_counter4.sv
// Four-digit BCD event counter that saturates at 9999 instead of wrapping.
module bcd_counter4 (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_q, count_d;
    logic        carry;

    always_comb begin
        count_d = count_q;
        carry   = inc && (count_q != 16'h9999);
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (count_q[4*d +: 4] == 4'd9) begin
                    count_d[4*d +: 4] = 4'd0;
                end else begin
                    count_d[4*d +: 4] = count_q[4*d +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) count_q <= 16'h0000;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/traffic_phase_sched.sv
// Round-robin green/yellow/all-red scheduler for four approaches with BCD arrival counts.
// Optional emergency preemption is compiled in when PREEMPT_EN is defined.
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int TW        = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic [3:0]  car_det,
`ifdef PREEMPT_EN
    input  logic        preempt_valid,
    input  logic [1:0]  preempt_idx,
`endif
    output logic [11:0] light,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [15:0] ns_count,
    output logic [15:0] sn_count,
    output logic [15:0] ew_count,
    output logic [15:0] we_count
);

    localparam logic [TW:0] GMIN_C = (TW+1)'(GREEN_MIN);
    localparam logic [TW:0] GMAX_C = (TW+1)'(GREEN_MAX);
    localparam logic [TW:0] YEL_C  = (TW+1)'(YELLOW_T);
    localparam logic [TW:0] AR_C   = (TW+1)'(ALLRED_T);

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      pend_q, pend_d;
    logic [3:0]      sync1_q, sync2_q, sync3_q;
    logic [11:0]     light_q;
    logic            busy_q;
    logic [3:0]      arr, green_mask;
    logic [TW:0]     t_inc;
    logic            other_pend, pv;
    logic [1:0]      pidx;

`ifdef PREEMPT_EN
    assign pv   = preempt_valid;
    assign pidx = preempt_idx;
`else
    assign pv   = 1'b0;
    assign pidx = 2'd0;
`endif

    assign arr = sync2_q & ~sync3_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        timer_d    = timer_q;
        t_inc      = {1'b0, timer_q} + {{TW{1'b0}}, 1'b1};
        other_pend = |(pend_q & ~(4'b0001 << grant_q));
        unique case (state_q)
            IDLE: begin
                if (pv) begin
                    state_d = GREEN;
                    grant_d = pidx;
                end else if (|pend_q) begin
                    state_d = GREEN;
                    grant_d = rr_pick(pend_q, grant_q);
                end
            end
            GREEN: begin
                if (pv) begin
                    if (tick && pidx != grant_q) state_d = YELLOW;
                end else if (tick && other_pend && (t_inc >= GMIN_C || t_inc >= GMAX_C)) begin
                    state_d = YELLOW;
                end
            end
            YELLOW: if (tick && t_inc == YEL_C) state_d = ALLRED;
            ALLRED: begin
                if (tick && t_inc == AR_C) begin
                    if (pv) begin
                        state_d = GREEN;
                        grant_d = pidx;
                    end else if (|pend_q) begin
                        state_d = GREEN;
                        grant_d = rr_pick(pend_q, grant_q);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Arrivals on the green approach count but never request service again.
        green_mask = (state_q == GREEN) ? (4'b0001 << grant_q) : 4'b0000;
        pend_d     = pend_q | (arr & ~green_mask);
        if (state_d == GREEN && state_q != GREEN) pend_d[grant_d] = 1'b0;

        if (state_d != state_q)            timer_d = '0;
        else if (tick && timer_q != '1)    timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 2'd0;
            timer_q <= '0;
            pend_q  <= 4'b0000;
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            sync3_q <= 4'b0000;
            light_q <= {4{LAMP_RED}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            sync1_q <= car_det;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            light_q <= lamp_drive(state_d, grant_d);
            busy_q  <= (state_d == GREEN) || (state_d == YELLOW);
        end
    end

    assign light = light_q;
    assign grant = grant_q;
    assign busy  = busy_q;

    bcd_counter4 u_ns (.clock(clock), .reset(reset), .inc(arr[IDX_NS]), .count(ns_count));
    bcd_counter4 u_sn (.clock(clock), .reset(reset), .inc(arr[IDX_SN]), .count(sn_count));
    bcd_counter4 u_ew (.clock(clock), .reset(reset), .inc(arr[IDX_EW]), .count(ew_count));
    bcd_counter4 u_we (.clock(clock), .reset(reset), .inc(arr[IDX_WE]), .count(we_count));

endmodule
